ipd_queue_stage: RTL and testbench

//  Pre-decode stage with a DEPTH-entry decoupling queue between the IF and ID stages.

---
 rtl/ipd_queue_stage.sv | 145 ++++++++++++++
 tb/tb_ipd_queue_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipd_queue_stage.sv
// Pre-decode stage: decodes IF instructions at enqueue and buffers them in a DEPTH-entry FIFO toward ID.
// Head visible one cycle after enqueue into an empty queue; IF stalls only when full, flush drops everything.
module ipd_queue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_pred_pc,
    input  logic [31:0]      if_inst,
    output logic             ipd_allow_in,
    input  logic             flush,
    input  logic             id_allow_in,
    output logic             ipd_to_id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pred_pc,
    output logic [25:0]      id_inst_type,
    output logic [31:0]      id_imm,
    output logic [4:0]       id_raddr1,
    output logic [4:0]       id_raddr2,
    output logic [4:0]       id_waddr,
    output logic [CNT_W-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam int T_ADDI = 25, T_ADD = 24, T_SUB = 23, T_OR = 22, T_ORI = 21, T_NOR = 20;
    localparam int T_ANDI = 19, T_AND = 18, T_XOR = 17, T_SRLI = 16, T_SLLI = 15, T_SRAI = 14;
    localparam int T_LU12I = 13, T_PCADDU12I = 12, T_SLT = 11, T_SLTU = 10, T_MUL = 9;
    localparam int T_JIRL = 8, T_B = 7, T_BEQ = 6, T_BNE = 5, T_BL = 4;
    localparam int T_STW = 3, T_LDW = 2, T_STB = 1, T_LDB = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic [25:0] inst_type;
        logic [31:0] imm;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic [4:0]  waddr;
    } entry_t;

    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    logic [4:0]  rd, rj, rk;
    logic [25:0] dec_type;
    logic        is_alu3, is_shift, is_mem, is_store, rj_src1, has_wb;
    entry_t      dec_entry;

    assign op17 = if_inst[31:15];
    assign op10 = if_inst[31:22];
    assign op7  = if_inst[31:25];
    assign op6  = if_inst[31:26];
    assign rk   = if_inst[14:10];
    assign rj   = if_inst[9:5];
    assign rd   = if_inst[4:0];

    assign dec_type = {
        op10 == 10'h00a,   op17 == 17'h00020, op17 == 17'h00022, op17 == 17'h0002a,
        op10 == 10'h00e,   op17 == 17'h00028, op10 == 10'h00d,   op17 == 17'h00029,
        op17 == 17'h0002b, op17 == 17'h00089, op17 == 17'h00081, op17 == 17'h00091,
        op7  == 7'h0a,     op7  == 7'h0e,     op17 == 17'h00024, op17 == 17'h00025,
        op17 == 17'h00038, op6  == 6'h13,     op6  == 6'h14,     op6  == 6'h16,
        op6  == 6'h17,     op6  == 6'h15,     op10 == 10'h0a6,   op10 == 10'h0a2,
        op10 == 10'h0a4,   op10 == 10'h0a0
    };

    assign is_alu3  = dec_type[T_ADD] | dec_type[T_SUB] | dec_type[T_OR] | dec_type[T_NOR]
                    | dec_type[T_AND] | dec_type[T_XOR] | dec_type[T_SLT] | dec_type[T_SLTU]
                    | dec_type[T_MUL];
    assign is_shift = dec_type[T_SRLI] | dec_type[T_SLLI] | dec_type[T_SRAI];
    assign is_store = dec_type[T_STW] | dec_type[T_STB];
    assign is_mem   = is_store | dec_type[T_LDW] | dec_type[T_LDB];
    assign rj_src1  = dec_type[T_ADDI] | dec_type[T_ORI] | dec_type[T_ANDI] | is_shift
                    | dec_type[T_JIRL] | dec_type[T_BEQ] | dec_type[T_BNE] | is_mem;
    assign has_wb   = is_alu3 | is_shift | dec_type[T_ADDI] | dec_type[T_ORI] | dec_type[T_ANDI]
                    | dec_type[T_LU12I] | dec_type[T_PCADDU12I] | dec_type[T_JIRL]
                    | dec_type[T_LDW] | dec_type[T_LDB];

    always_comb begin
        dec_entry           = '0;
        dec_entry.pc        = if_pc;
        dec_entry.pred_pc   = if_pred_pc;
        dec_entry.inst_type = dec_type;
        dec_entry.raddr1    = is_alu3 ? rk : (rj_src1 ? rj : 5'd0);
        dec_entry.raddr2    = is_alu3 ? rj : ((dec_type[T_BEQ] | dec_type[T_BNE] | is_store) ? rd : 5'd0);
        dec_entry.waddr     = has_wb ? rd : 5'd0;
        if (dec_type[T_ADDI] | is_mem)
            dec_entry.imm = {{20{if_inst[21]}}, if_inst[21:10]};
        else if (dec_type[T_ORI] | dec_type[T_ANDI])
            dec_entry.imm = {20'd0, if_inst[21:10]};
        else if (is_shift)
            dec_entry.imm = {27'd0, if_inst[14:10]};
        else if (dec_type[T_LU12I] | dec_type[T_PCADDU12I])
            dec_entry.imm = {if_inst[24:5], 12'd0};
        else if (dec_type[T_JIRL] | dec_type[T_BEQ] | dec_type[T_BNE])
            dec_entry.imm = {{14{if_inst[25]}}, if_inst[25:10], 2'b00};
        else if (dec_type[T_B] | dec_type[T_BL])
            dec_entry.imm = {{4{if_inst[9]}}, if_inst[9:0], if_inst[25:10], 2'b00};
    end

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             enq, deq;
    entry_t           head;

    assign ipd_allow_in    = (occupancy != CNT_W'(DEPTH));
    assign ipd_to_id_valid = (occupancy != '0) & ~flush;
    assign enq             = if_valid & ipd_allow_in & ~flush;
    assign deq             = ipd_to_id_valid & id_allow_in;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            occupancy <= occupancy + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Payload storage carries no reset: entries are only observed through the valid mask.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= dec_entry;
    end

    assign head = ipd_to_id_valid ? mem[rd_ptr] : '0;

    assign id_pc        = head.pc;
    assign id_pred_pc   = head.pred_pc;
    assign id_inst_type = head.inst_type;
    assign id_imm       = head.imm;
    assign id_raddr1    = head.raddr1;
    assign id_raddr2    = head.raddr2;
    assign id_waddr     = head.waddr;
endmodule

// File: tb/tb_ipd_queue_stage.sv
// Bench for ipd_queue_stage: decode vector table, queue corner sequences, randomized run vs FIFO model.
module tb_ipd_queue_stage;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             if_valid;
    logic [31:0]      if_pc, if_pred_pc, if_inst;
    logic             ipd_allow_in, flush, id_allow_in, ipd_to_id_valid;
    logic [31:0]      id_pc, id_pred_pc, id_imm;
    logic [25:0]      id_inst_type;
    logic [4:0]       id_raddr1, id_raddr2, id_waddr;
    logic [CNT_W-1:0] occupancy;

    ipd_queue_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc), .if_pred_pc(if_pred_pc),
        .if_inst(if_inst), .ipd_allow_in(ipd_allow_in), .flush(flush), .id_allow_in(id_allow_in),
        .ipd_to_id_valid(ipd_to_id_valid), .id_pc(id_pc), .id_pred_pc(id_pred_pc),
        .id_inst_type(id_inst_type), .id_imm(id_imm), .id_raddr1(id_raddr1),
        .id_raddr2(id_raddr2), .id_waddr(id_waddr), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred;
        logic [25:0] ty;
        logic [31:0] imm;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  w;
    } ent_t;

    // Operand formats: 0 R3, 1 si12 arith, 2 ui12, 3 ui5 shift, 4 ui20, 5 jirl, 6 beq/bne, 7 b/bl, 8 load, 9 store
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          bitn;
        int          fmt;
    } op_t;

    typedef struct {
        logic [31:0] inst;
        logic [25:0] ty;
        logic [31:0] imm;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  w;
    } vec_t;

    op_t  ops [26];
    vec_t vecs [16];
    ent_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] pc_ctr = 32'h1c00_0000;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic ent_t model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] pred);
        ent_t e;
        int   fmt, v;
        e = '0;
        e.pc = pc;
        e.pred = pred;
        fmt = -1;
        for (int i = 0; i < 26; i++)
            if ((inst & ops[i].mask) == ops[i].match) begin
                fmt = ops[i].fmt;
                e.ty[ops[i].bitn] = 1'b1;
            end
        case (fmt)
            0: begin e.r1 = inst[14:10]; e.r2 = inst[9:5]; e.w = inst[4:0]; end
            1, 8: begin
                v = int'(inst[21:10]); if (v >= 2048) v -= 4096;
                e.imm = 32'(v); e.r1 = inst[9:5]; e.w = inst[4:0];
            end
            2: begin e.imm = 32'(inst[21:10]); e.r1 = inst[9:5]; e.w = inst[4:0]; end
            3: begin e.imm = 32'(inst[14:10]); e.r1 = inst[9:5]; e.w = inst[4:0]; end
            4: begin e.imm = 32'(inst[24:5]) * 32'd4096; e.w = inst[4:0]; end
            5, 6: begin
                v = int'(inst[25:10]); if (v >= 32768) v -= 65536;
                e.imm = 32'(v * 4); e.r1 = inst[9:5];
                if (fmt == 5) e.w = inst[4:0]; else e.r2 = inst[4:0];
            end
            7: begin
                v = int'({inst[9:0], inst[25:10]}); if (v >= (1 << 25)) v -= (1 << 26);
                e.imm = 32'(v * 4);
            end
            9: begin
                v = int'(inst[21:10]); if (v >= 2048) v -= 4096;
                e.imm = 32'(v); e.r1 = inst[9:5]; e.r2 = inst[4:0];
            end
            default: e = '{pc: pc, pred: pred, default: '0};
        endcase
        return e;
    endfunction

    task automatic model_check();
        logic ev;
        ent_t act, req;
        ev = (exp_q.size() != 0) && !flush;
        chk("occupancy", 160'(occupancy), 160'(exp_q.size()));
        chk("allow_in", 160'(ipd_allow_in), 160'(exp_q.size() != DEPTH));
        chk("valid", 160'(ipd_to_id_valid), 160'(ev));
        act = {id_pc, id_pred_pc, id_inst_type, id_imm, id_raddr1, id_raddr2, id_waddr};
        req = ev ? exp_q[0] : '0;
        chk("head", 160'(act), 160'(req));
    endtask

    task automatic drive(input logic iv, input logic [31:0] inst, input logic ia, input logic fl);
        @(negedge clk);
        if_valid    = iv;
        if_inst     = inst;
        if_pc       = pc_ctr;
        if_pred_pc  = $urandom();
        id_allow_in = ia;
        flush       = fl;
        pc_ctr      = pc_ctr + 32'd4;
        #1;
        model_check();
    endtask

    task automatic tick();
        logic enq, deq;
        ent_t tmp;
        enq = if_valid && (exp_q.size() != DEPTH) && !flush;
        deq = (exp_q.size() != 0) && !flush && id_allow_in;
        if (flush) exp_q.delete();
        else begin
            if (deq) tmp = exp_q.pop_front();
            if (enq) exp_q.push_back(model_decode(if_inst, if_pc, if_pred_pc));
        end
        @(posedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        int k;
        k = $urandom_range(0, 26);
        if (k == 26) return $urandom();
        return ops[k].match | ($urandom() & ~ops[k].mask);
    endfunction

    initial begin
        logic [31:0] p0;
        ops = '{
            '{32'hffc00000, 32'h02800000, 25, 1}, '{32'hffff8000, 32'h00100000, 24, 0},
            '{32'hffff8000, 32'h00110000, 23, 0}, '{32'hffff8000, 32'h00150000, 22, 0},
            '{32'hffc00000, 32'h03800000, 21, 2}, '{32'hffff8000, 32'h00140000, 20, 0},
            '{32'hffc00000, 32'h03400000, 19, 2}, '{32'hffff8000, 32'h00148000, 18, 0},
            '{32'hffff8000, 32'h00158000, 17, 0}, '{32'hffff8000, 32'h00448000, 16, 3},
            '{32'hffff8000, 32'h00408000, 15, 3}, '{32'hffff8000, 32'h00488000, 14, 3},
            '{32'hfe000000, 32'h14000000, 13, 4}, '{32'hfe000000, 32'h1c000000, 12, 4},
            '{32'hffff8000, 32'h00120000, 11, 0}, '{32'hffff8000, 32'h00128000, 10, 0},
            '{32'hffff8000, 32'h001c0000,  9, 0}, '{32'hfc000000, 32'h4c000000,  8, 5},
            '{32'hfc000000, 32'h50000000,  7, 7}, '{32'hfc000000, 32'h58000000,  6, 6},
            '{32'hfc000000, 32'h5c000000,  5, 6}, '{32'hfc000000, 32'h54000000,  4, 7},
            '{32'hffc00000, 32'h29800000,  3, 9}, '{32'hffc00000, 32'h28800000,  2, 8},
            '{32'hffc00000, 32'h29000000,  1, 9}, '{32'hffc00000, 32'h28000000,  0, 8}
        };
        vecs[0]  = '{32'h02bffc41, 26'h2000000, 32'hffffffff, 5'd2,  5'd0, 5'd1};  // addi.w r1,r2,-1
        vecs[1]  = '{32'h00101483, 26'h1000000, 32'h00000000, 5'd5,  5'd4, 5'd3};  // add.w r3,r4,r5
        vecs[2]  = '{32'h03aaf0e6, 26'h0200000, 32'h00000abc, 5'd7,  5'd0, 5'd6};  // ori r6,r7,0xabc
        vecs[3]  = '{32'h0048fd28, 26'h0004000, 32'h0000001f, 5'd9,  5'd0, 5'd8};  // srai.w r8,r9,31
        vecs[4]  = '{32'h1500002a, 26'h0002000, 32'h80001000, 5'd0,  5'd0, 5'd10}; // lu12i.w
        vecs[5]  = '{32'h5ffffc85, 26'h0000020, 32'hfffffffc, 5'd4,  5'd5, 5'd0};  // bne r4,r5,-4
        vecs[6]  = '{32'h298020e6, 26'h0000008, 32'h00000008, 5'd7,  5'd6, 5'd0};  // st.w r6,r7,8
        vecs[7]  = '{32'h54010000, 26'h0000010, 32'h00000100, 5'd0,  5'd0, 5'd0};  // bl +0x100
        vecs[8]  = '{32'h53fffbff, 26'h0000080, 32'hfffffff8, 5'd0,  5'd0, 5'd0};  // b -8
        vecs[9]  = '{32'h4c000441, 26'h0000100, 32'h00000004, 5'd2,  5'd0, 5'd1};  // jirl r1,r2,4
        vecs[10] = '{32'h282001ac, 26'h0000001, 32'hfffff800, 5'd13, 5'd0, 5'd12}; // ld.b -2048
        vecs[11] = '{32'h001c0c41, 26'h0000200, 32'h00000000, 5'd3,  5'd2, 5'd1};  // mul.w
        vecs[12] = '{32'hffffffff, 26'h0000000, 32'h00000000, 5'd0,  5'd0, 5'd0};  // unknown
        vecs[13] = '{32'h1c2468a5, 26'h0001000, 32'h12345000, 5'd0,  5'd0, 5'd5};  // pcaddu12i
        vecs[14] = '{32'h037ffc62, 26'h0080000, 32'h00000fff, 5'd3,  5'd0, 5'd2};  // andi 0xfff
        vecs[15] = '{32'h0012a507, 26'h0000400, 32'h00000000, 5'd9,  5'd8, 5'd7};  // sltu

        resetn = 1'b0; if_valid = 1'b0; if_pc = '0; if_pred_pc = '0; if_inst = '0;
        flush = 1'b0; id_allow_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_occupancy", 160'(occupancy), 160'(0));
        chk("rst_valid", 160'(ipd_to_id_valid), 160'(0));
        chk("rst_allow", 160'(ipd_allow_in), 160'(1));
        chk("rst_outputs", 160'({id_pc, id_pred_pc, id_inst_type, id_imm, id_raddr1, id_raddr2, id_waddr}), 160'(0));
        resetn = 1'b1;
        @(posedge clk);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].inst, 1'b0, 1'b0);
            tick();
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("vec%0d_valid", i), 160'(ipd_to_id_valid), 160'(1));
            chk($sformatf("vec%0d_decode", i),
                160'({id_inst_type, id_imm, id_raddr1, id_raddr2, id_waddr}),
                160'({vecs[i].ty, vecs[i].imm, vecs[i].r1, vecs[i].r2, vecs[i].w}));
            tick();
        end

        p0 = pc_ctr;
        for (int i = 0; i < 4; i++) begin drive(1'b1, rand_inst(), 1'b0, 1'b0); tick(); end
        drive(1'b1, rand_inst(), 1'b0, 1'b0);
        chk("full_occ", 160'(occupancy), 160'(4));
        chk("full_allow", 160'(ipd_allow_in), 160'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            chk("drain_order", 160'(id_pc), 160'(p0 + 32'(4 * i)));
            tick();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drained_occ", 160'(occupancy), 160'(0));
        tick();

        for (int i = 0; i < 4; i++) begin drive(1'b1, rand_inst(), 1'b0, 1'b0); tick(); end
        drive(1'b1, rand_inst(), 1'b1, 1'b0);
        tick();
        drive(1'b1, rand_inst(), 1'b1, 1'b0);
        chk("full_deq_occ", 160'(occupancy), 160'(3));
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("both_occ", 160'(occupancy), 160'(3));
        tick();

        drive(1'b1, rand_inst(), 1'b1, 1'b1);
        chk("flush_valid_mask", 160'(ipd_to_id_valid), 160'(0));
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("flush_occ", 160'(occupancy), 160'(0));
        chk("flush_valid", 160'(ipd_to_id_valid), 160'(0));
        tick();
        p0 = pc_ctr;
        drive(1'b1, 32'h02bffc41, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("post_flush_head", 160'(id_pc), 160'(p0));
        tick();

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 29) == 0));
            tick();
        end

        for (int i = 0; i < 3; i++) begin drive(1'b1, rand_inst(), 1'b0, 1'b0); tick(); end
        @(negedge clk);
        if_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_occ", 160'(occupancy), 160'(0));
        chk("midrst_valid", 160'(ipd_to_id_valid), 160'(0));
        exp_q.delete();
        #1 resetn = 1'b1;
        @(posedge clk);
        drive(1'b1, rand_inst(), 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
